wb_syscon_ctrl: RTL and testbench

- Parametrised Wishbone system controller for one clock domain.
- Takes the board clock and the asynchronous active-low reset, and produces a synchronised, stretched Wishbone reset. Reset assertion is asynchronous; deassertion is synchronous.
- Adds a software reset request, an optional watchdog, a programmable clock-enable tick and a free-running cycle stamp.
- Sits between the clock/reset source and every Wishbone master and slave in the design or bench.

---
 rtl/wb_syscon_ctrl.sv | 147 ++++++++++++++
 tb/tb_wb_syscon_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_syscon_ctrl.sv
// Wishbone system controller: synchronised, stretched reset plus software reset, tick divider and cycle stamp.
// Define WB_SYSCON_WDT_EN to build in the watchdog.
module wb_syscon_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned WDT_WIDTH   = 16,
    parameter int unsigned STAMP_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_rst_req,
    input  logic [DIV_WIDTH-1:0]   div_ratio,
    input  logic                   wdt_kick,
    input  logic [WDT_WIDTH-1:0]   wdt_limit,
    output logic                   wb_rst_o,
    output logic                   rst_done_o,
    output logic                   tick_o,
    output logic [STAMP_WIDTH-1:0] cycle_cnt_o,
    output logic [1:0]             rst_cause_o
);

    localparam int unsigned       HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);
    localparam logic [1:0]        CAUSE_EXT = 2'b01;
    localparam logic [1:0]        CAUSE_SW  = 2'b10;
    localparam logic [1:0]        CAUSE_WDT = 2'b11;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic [STAMP_WIDTH-1:0] stamp_q, stamp_d;
    logic [1:0]             cause_q, cause_d;
    logic                   run_stay;
    logic                   tick;
    logic                   wdt_expire;

`ifdef WB_SYSCON_WDT_EN
    logic [WDT_WIDTH-1:0] wdt_q, wdt_d;

    assign wdt_expire = (state_q == ST_RUN) && (wdt_limit != '0) && !wdt_kick && (wdt_q == wdt_limit);

    always_comb begin
        wdt_d = '0;
        if (run_stay) begin
            wdt_d = wdt_kick ? '0 : wdt_q + WDT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic unused_wdt;

    assign wdt_expire = 1'b0;
    assign unused_wdt = ^{wdt_kick, wdt_limit};
`endif

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        case (state_q)
            // HOLD is entered on the same edge the last stage captures 1, so the
            // release lands SYNC_STAGES+RST_CYCLES edges after rst rises.
            ST_SYNC: begin
                if (sync_d[SYNC_STAGES-1]) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (sw_rst_req) begin
                    hold_d  = HOLD_LOAD;
                    cause_d = CAUSE_SW;
                end else if (hold_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_rst_req) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                    cause_d = CAUSE_SW;
                end else if (wdt_expire) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                    cause_d = CAUSE_WDT;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        run_stay  = (state_q == ST_RUN) && (state_d == ST_RUN);
        tick      = (state_q == ST_RUN) && (div_cnt_q >= div_ratio);
        div_cnt_d = (run_stay && !tick) ? div_cnt_q + DIV_WIDTH'(1) : '0;

        stamp_d = stamp_q;
        if (run_stay) begin
            stamp_d = stamp_q + STAMP_WIDTH'(1);
        end else if (state_q == ST_RUN) begin
            stamp_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_SYNC;
            sync_q    <= '0;
            hold_q    <= '0;
            div_cnt_q <= '0;
            stamp_q   <= '0;
            cause_q   <= CAUSE_EXT;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            hold_q    <= hold_d;
            div_cnt_q <= div_cnt_d;
            stamp_q   <= stamp_d;
            cause_q   <= cause_d;
        end
    end

    assign rst_done_o  = (state_q == ST_RUN) && sync_q[SYNC_STAGES-1];
    assign wb_rst_o    = !rst_done_o;
    assign tick_o      = tick;
    assign cycle_cnt_o = stamp_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_wb_syscon_ctrl.sv
// Randomised and directed bench for wb_syscon_ctrl against an edge-index reference model.
`timescale 1ns/1ps
module tb_wb_syscon_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int RST_CYCLES  = 4;
    localparam int DIV_WIDTH   = 8;
    localparam int WDT_WIDTH   = 16;
    localparam int STAMP_WIDTH = 32;
`ifdef WB_SYSCON_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic                   clk        = 1'b0;
    logic                   rst        = 1'b0;
    logic                   sw_rst_req = 1'b0;
    logic [DIV_WIDTH-1:0]   div_ratio  = 8'd3;
    logic                   wdt_kick   = 1'b0;
    logic [WDT_WIDTH-1:0]   wdt_limit  = '0;
    logic                   wb_rst_o;
    logic                   rst_done_o;
    logic                   tick_o;
    logic [STAMP_WIDTH-1:0] cycle_cnt_o;
    logic [1:0]             rst_cause_o;

    int checks = 0;
    int errors = 0;

    wb_syscon_ctrl #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_CYCLES (RST_CYCLES),
        .DIV_WIDTH  (DIV_WIDTH),
        .WDT_WIDTH  (WDT_WIDTH),
        .STAMP_WIDTH(STAMP_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .div_ratio  (div_ratio),
        .wdt_kick   (wdt_kick),
        .wdt_limit  (wdt_limit),
        .wb_rst_o   (wb_rst_o),
        .rst_done_o (rst_done_o),
        .tick_o     (tick_o),
        .cycle_cnt_o(cycle_cnt_o),
        .rst_cause_o(rst_cause_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges are numbered globally; reset is asserted until edge rst_end, and
    // every trigger simply moves rst_end to trigger_edge+RST_CYCLES.
    int       ecount    = 0;
    int       rel_edge  = 0;
    int       rst_end   = 1 << 30;
    int       last_wrap = 0;
    int       wdt_zero  = 0;
    logic [1:0] m_cause = 2'b01;
    int       n;
    bit       prev_run, tick_prev, expire;

    always @(posedge clk) begin
        ecount = ecount + 1;
        n      = ecount;
        if (!rst) begin
            rel_edge = n;
            rst_end  = n + SYNC_STAGES + RST_CYCLES;
            m_cause  = 2'b01;
        end else begin
            prev_run  = (n - 1) >= rst_end;
            tick_prev = prev_run && ((n - 1 - last_wrap) >= int'(div_ratio));
            expire    = WDT_ON && prev_run && (wdt_limit != 0) && !wdt_kick &&
                        (((n - 1 - wdt_zero) & 32'hFFFF) == int'(wdt_limit));
            if (((n - 1) >= rel_edge + SYNC_STAGES) && sw_rst_req) begin
                rst_end = n + RST_CYCLES;
                m_cause = 2'b10;
            end else if (expire) begin
                rst_end = n + RST_CYCLES;
                m_cause = 2'b11;
            end
            if (prev_run && tick_prev) last_wrap = n;
            if (prev_run && wdt_kick) wdt_zero = n;
            if (!prev_run && n >= rst_end) begin
                last_wrap = n;
                wdt_zero  = n;
            end
        end
    end

    bit         e_run, e_tick;
    logic [31:0] e_stamp;
    logic [1:0]  e_cause;

    always @(negedge clk) begin
        e_run   = rst && (ecount >= rst_end);
        e_tick  = e_run && ((ecount - last_wrap) >= int'(div_ratio));
        e_stamp = e_run ? 32'(ecount - rst_end) : 32'd0;
        e_cause = rst ? m_cause : 2'b01;
        chk("wb_rst_o",    64'(wb_rst_o),    64'(!e_run));
        chk("rst_done_o",  64'(rst_done_o),  64'(e_run));
        chk("tick_o",      64'(tick_o),      64'(e_tick));
        chk("cycle_cnt_o", 64'(cycle_cnt_o), 64'(e_stamp));
        chk("rst_cause_o", 64'(rst_cause_o), 64'(e_cause));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    int hi_cnt;

    initial begin
        // Power-on: rst low over edges 1..5, edges after release counted from 1.
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (5) cyc();
        chk("por_hold_edge5", 64'(wb_rst_o), 64'd1);
        cyc();
        chk("por_release_wb", 64'(wb_rst_o), 64'd0);
        chk("por_done", 64'(rst_done_o), 64'd1);
        chk("por_cause", 64'(rst_cause_o), 64'd1);
        chk("por_stamp0", 64'(cycle_cnt_o), 64'd0);
        chk("tick_run1", 64'(tick_o), 64'd0);
        repeat (3) cyc();
        chk("tick_run4", 64'(tick_o), 64'd1);
        chk("stamp_run4", 64'(cycle_cnt_o), 64'd3);
        cyc();
        chk("tick_run5", 64'(tick_o), 64'd0);
        div_ratio = 8'd0;
        cyc();
        chk("tick_div0_a", 64'(tick_o), 64'd1);
        cyc();
        chk("tick_div0_b", 64'(tick_o), 64'd1);

        // Software reset: exactly RST_CYCLES cycles of reset.
        sw_rst_req = 1'b1;
        cyc();
        sw_rst_req = 1'b0;
        chk("sw_wb", 64'(wb_rst_o), 64'd1);
        chk("sw_cause", 64'(rst_cause_o), 64'd2);
        chk("sw_stamp", 64'(cycle_cnt_o), 64'd0);
        repeat (3) cyc();
        chk("sw_wb_last", 64'(wb_rst_o), 64'd1);
        cyc();
        chk("sw_wb_end", 64'(wb_rst_o), 64'd0);

        // Second request in HOLD extends reset from that request.
        sw_rst_req = 1'b1;
        cyc();
        sw_rst_req = 1'b0;
        repeat (2) cyc();
        sw_rst_req = 1'b1;
        cyc();
        sw_rst_req = 1'b0;
        repeat (3) cyc();
        chk("ext_wb_last", 64'(wb_rst_o), 64'd1);
        cyc();
        chk("ext_wb_end", 64'(wb_rst_o), 64'd0);

        // Watchdog timeout with limit 10 and no kick.
        wdt_limit  = 16'd10;
        sw_rst_req = 1'b1;
        cyc();
        sw_rst_req = 1'b0;
        repeat (14) cyc();
        chk("wdt_pre", 64'(wb_rst_o), 64'd0);
        cyc();
`ifdef WB_SYSCON_WDT_EN
        chk("wdt_fire_wb", 64'(wb_rst_o), 64'd1);
        chk("wdt_fire_cause", 64'(rst_cause_o), 64'd3);
`else
        chk("wdt_absent_wb", 64'(wb_rst_o), 64'd0);
        chk("wdt_absent_cause", 64'(rst_cause_o), 64'd2);
`endif

        // Software request coinciding with expiry.
        sw_rst_req = 1'b1;
        cyc();
        sw_rst_req = 1'b0;
        repeat (14) cyc();
        sw_rst_req = 1'b1;
        cyc();
        sw_rst_req = 1'b0;
        chk("sw_vs_wdt_cause", 64'(rst_cause_o), 64'd2);
        chk("sw_vs_wdt_wb", 64'(wb_rst_o), 64'd1);

        // Kick coinciding with expiry.
        repeat (14) cyc();
        wdt_kick = 1'b1;
        cyc();
        wdt_kick = 1'b0;
        chk("kick_vs_wdt_wb", 64'(wb_rst_o), 64'd0);

        hi_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            wdt_kick = ((i % 8) == 7);
            cyc();
            hi_cnt += int'(wb_rst_o);
        end
        wdt_kick = 1'b0;
        chk("kick8_no_rst", 64'(hi_cnt), 64'd0);

        wdt_limit = '0;
        hi_cnt    = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            hi_cnt += int'(wb_rst_o);
        end
        chk("limit0_no_rst", 64'(hi_cnt), 64'd0);

        // Randomised traffic, checked every cycle by the compare process.
        for (int i = 0; i < 800; i++) begin
            sw_rst_req = ($urandom_range(0, 63) == 0);
            wdt_kick   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) div_ratio = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) wdt_limit = 16'($urandom_range(0, 3) * 8);
            cyc();
        end

        // Asynchronous reset in RUN.
        sw_rst_req = 1'b0;
        wdt_kick   = 1'b0;
        wdt_limit  = '0;
        repeat (10) cyc();
        chk("pre_async_run", 64'(wb_rst_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("async_wb", 64'(wb_rst_o), 64'd1);
        chk("async_done", 64'(rst_done_o), 64'd0);
        chk("async_tick", 64'(tick_o), 64'd0);
        chk("async_stamp", 64'(cycle_cnt_o), 64'd0);
        chk("async_cause", 64'(rst_cause_o), 64'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (5) cyc();
        chk("repor_hold", 64'(wb_rst_o), 64'd1);
        cyc();
        chk("repor_wb", 64'(wb_rst_o), 64'd0);
        chk("repor_cause", 64'(rst_cause_o), 64'd1);
        chk("repor_stamp", 64'(cycle_cnt_o), 64'd0);
        repeat (5) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
